// File: rtl/reg_rename_file.sv
// reg_rename_file: architectural register file with ROB rename tags and combinational operand lookup.
// Optional macro REG_COMMIT_BYPASS_EN forwards a same-cycle matching commit into the lookups.
module reg_rename_file #(
   parameter int ROB_POS_W = 4,
   parameter int REG_CNT   = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic                 rollback,
   input  logic                 issue,
   input  logic [4:0]           issue_rd,
   input  logic [ROB_POS_W-1:0] issue_rob_pos,
   input  logic                 reg_write,
   input  logic [4:0]           reg_rd,
   input  logic [31:0]          reg_val,
   input  logic [ROB_POS_W-1:0] commit_rob_pos,
   input  logic [4:0]           rs1_pos,
   input  logic [4:0]           rs2_pos,
   output logic                 rs1_busy,
   output logic [ROB_POS_W-1:0] rs1_tag,
   output logic [31:0]          rs1_val,
   output logic                 rs2_busy,
   output logic [ROB_POS_W-1:0] rs2_tag,
   output logic [31:0]          rs2_val
);
   logic [31:0]          val  [REG_CNT];
   logic [ROB_POS_W-1:0] tag  [REG_CNT];
   logic [REG_CNT-1:0]   busy;
   logic                 fwd1, fwd2;

   // Later assignments override earlier ones: rollback beats issue beats the commit busy clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= '0;
         for (int i = 0; i < REG_CNT; i++) begin
            val[i] <= '0;
            tag[i] <= '0;
         end
      end else if (rdy) begin
         if (reg_write && reg_rd != '0) begin
            val[reg_rd] <= reg_val;
            if (busy[reg_rd] && tag[reg_rd] == commit_rob_pos) busy[reg_rd] <= 1'b0;
         end
         if (rollback) begin
            busy <= '0;
            for (int i = 0; i < REG_CNT; i++) tag[i] <= '0;
         end else if (issue && issue_rd != '0) begin
            busy[issue_rd] <= 1'b1;
            tag[issue_rd]  <= issue_rob_pos;
         end
      end
   end

`ifdef REG_COMMIT_BYPASS_EN
   assign fwd1 = reg_write && reg_rd == rs1_pos && rs1_pos != '0 && busy[rs1_pos] && tag[rs1_pos] == commit_rob_pos;
   assign fwd2 = reg_write && reg_rd == rs2_pos && rs2_pos != '0 && busy[rs2_pos] && tag[rs2_pos] == commit_rob_pos;
`else
   assign fwd1 = 1'b0;
   assign fwd2 = 1'b0;
`endif

   assign rs1_busy = rs1_pos != '0 && busy[rs1_pos] && !fwd1;
   assign rs1_tag  = rs1_pos == '0 ? '0 : tag[rs1_pos];
   assign rs1_val  = fwd1 ? reg_val : rs1_pos == '0 ? '0 : val[rs1_pos];
   assign rs2_busy = rs2_pos != '0 && busy[rs2_pos] && !fwd2;
   assign rs2_tag  = rs2_pos == '0 ? '0 : tag[rs2_pos];
   assign rs2_val  = fwd2 ? reg_val : rs2_pos == '0 ? '0 : val[rs2_pos];
endmodule

// File: tb/tb_reg_rename_file.sv
// tb_reg_rename_file: directed self-checking bench for reg_rename_file.
module tb_reg_rename_file;
   logic        clk = 0, rst = 1, rdy = 1, rollback = 0, issue = 0, reg_write = 0;
   logic [4:0]  issue_rd = 0, reg_rd = 0, rs1_pos = 0, rs2_pos = 0;
   logic [3:0]  issue_rob_pos = 0, commit_rob_pos = 0;
   logic [31:0] reg_val = 0;
   logic        rs1_busy, rs2_busy;
   logic [3:0]  rs1_tag, rs2_tag;
   logic [31:0] rs1_val, rs2_val;
   int checks = 0, errors = 0;

   reg_rename_file #(.ROB_POS_W(4), .REG_CNT(32)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .issue(issue),
      .issue_rd(issue_rd), .issue_rob_pos(issue_rob_pos), .reg_write(reg_write),
      .reg_rd(reg_rd), .reg_val(reg_val), .commit_rob_pos(commit_rob_pos),
      .rs1_pos(rs1_pos), .rs2_pos(rs2_pos),
      .rs1_busy(rs1_busy), .rs1_tag(rs1_tag), .rs1_val(rs1_val),
      .rs2_busy(rs2_busy), .rs2_tag(rs2_tag), .rs2_val(rs2_val)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      issue = 0;
      reg_write = 0;
      rollback = 0;
   endtask

   task automatic do_issue(input logic [4:0] rd, input logic [3:0] pos);
      issue = 1; issue_rd = rd; issue_rob_pos = pos;
      cyc();
   endtask

   task automatic do_commit(input logic [4:0] rd, input logic [3:0] pos, input logic [31:0] v);
      reg_write = 1; reg_rd = rd; commit_rob_pos = pos; reg_val = v;
      cyc();
   endtask

   initial begin
      rs1_pos = 5;
      #2;
      chk("rst_busy", 32'(rs1_busy), 0);
      chk("rst_val", rs1_val, 0);
      #10 rst = 0;
      #1;
      chk("post_rst_busy", 32'(rs1_busy), 0);
      chk("post_rst_tag", 32'(rs1_tag), 0);
      chk("post_rst_val", rs1_val, 0);

      do_issue(0, 3);
      rs1_pos = 0; #1;
      chk("x0_busy", 32'(rs1_busy), 0);
      chk("x0_val", rs1_val, 0);

      do_issue(7, 2);
      rs1_pos = 7; #1;
      chk("ren_busy", 32'(rs1_busy), 1);
      chk("ren_tag", 32'(rs1_tag), 2);
      do_commit(7, 2, 32'h1234);
      chk("cmt_busy", 32'(rs1_busy), 0);
      chk("cmt_val", rs1_val, 32'h1234);

      do_issue(9, 1);
      do_issue(9, 4);
      do_commit(9, 1, 32'hAA);
      rs1_pos = 9; #1;
      chk("stale_val", rs1_val, 32'hAA);
      chk("stale_busy", 32'(rs1_busy), 1);
      chk("stale_tag", 32'(rs1_tag), 4);
      do_commit(9, 4, 32'hBB);
      chk("young_busy", 32'(rs1_busy), 0);
      chk("young_val", rs1_val, 32'hBB);

      do_issue(3, 6);
      reg_write = 1; reg_rd = 3; commit_rob_pos = 6; reg_val = 32'h55;
      issue = 1; issue_rd = 3; issue_rob_pos = 7;
      cyc();
      rs1_pos = 3; #1;
      chk("same_busy", 32'(rs1_busy), 1);
      chk("same_tag", 32'(rs1_tag), 7);
      chk("same_val", rs1_val, 32'h55);

      do_issue(1, 1);
      do_issue(2, 2);
      do_issue(31, 3);
      rollback = 1;
      issue = 1; issue_rd = 4; issue_rob_pos = 5;
      reg_write = 1; reg_rd = 1; commit_rob_pos = 0; reg_val = 32'h99;
      cyc();
      rs1_pos = 1; rs2_pos = 2; #1;
      chk("rb_x1_busy", 32'(rs1_busy), 0);
      chk("rb_x1_val", rs1_val, 32'h99);
      chk("rb_x2_busy", 32'(rs2_busy), 0);
      chk("rb_x2_tag", 32'(rs2_tag), 0);
      rs1_pos = 31; rs2_pos = 4; #1;
      chk("rb_x31_busy", 32'(rs1_busy), 0);
      chk("rb_x4_busy", 32'(rs2_busy), 0);
      chk("rb_x4_tag", 32'(rs2_tag), 0);
      rs1_pos = 3; #1;
      chk("rb_x3_tag", 32'(rs1_tag), 0);

      rdy = 0;
      issue = 1; issue_rd = 12; issue_rob_pos = 9;
      reg_write = 1; reg_rd = 7; commit_rob_pos = 2; reg_val = 32'hFFFF;
      cyc();
      rdy = 1;
      rs1_pos = 12; rs2_pos = 7; #1;
      chk("hold_busy", 32'(rs1_busy), 0);
      chk("hold_val", rs2_val, 32'h1234);

      do_issue(10, 3);
      rs2_pos = 10;
      reg_write = 1; reg_rd = 10; commit_rob_pos = 3; reg_val = 32'hDEAD;
      #1;
`ifdef REG_COMMIT_BYPASS_EN
      chk("byp_busy", 32'(rs2_busy), 0);
      chk("byp_val", rs2_val, 32'hDEAD);
`else
      chk("nobyp_busy", 32'(rs2_busy), 1);
      chk("nobyp_tag", 32'(rs2_tag), 3);
`endif
      cyc();
      chk("byp_after_busy", 32'(rs2_busy), 0);
      chk("byp_after_val", rs2_val, 32'hDEAD);

      do_commit(0, 0, 32'h5);
      rs1_pos = 0; #1;
      chk("x0_write_val", rs1_val, 0);

      do_issue(20, 11);
      #3 rst = 1;
      rs1_pos = 10; rs2_pos = 20; #1;
      chk("arst_val", rs1_val, 0);
      chk("arst_busy", 32'(rs2_busy), 0);
      chk("arst_tag", 32'(rs2_tag), 0);
      rst = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
